pipeline_stage_skid: RTL and testbench
======================================

// Module: pipeline_stage_skid
// PURPOSE
//   Parametrised elastic pipeline register for inter-stage boundaries (F/D, D/E, E/M, M/W).
//   Replaces fixed-field stage registers with a generic valid/ready stage with flush.
//   Optional skid buffer gives full throughput with a registered in_ready.
//   Control field is forced to a bubble value when invalid, so RW/MemWrite never fire on empty slots.
// PARAMETERS
//   DATA_W       32   width of payload (PC, ALU result, mem data, reg addr, ... concatenated)
//   CTRL_W       4    width of control field (RW, MD, AUIPC, ...)
//   SKID         1    1: two-entry stage, registered in_ready; 0: single entry, combinational in_ready
//   BUBBLE_CTRL  0    CTRL_W-bit value driven on out_ctrl whenever out_valid=0
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   flush      in   1        discard all held entries (branch mispredict / exception)
//   in_valid   in   1        upstream has a valid entry
//   in_ready   out  1        stage can accept this cycle
//   in_ctrl    in   CTRL_W   upstream control field
//   in_data    in   DATA_W   upstream payload
//   out_valid  out  1        stage presents a valid entry
//   out_ready  in   1        downstream accepts this cycle
//   out_ctrl   out  CTRL_W   control field; BUBBLE_CTRL when out_valid=0
//   out_data   out  DATA_W   payload; holds last value when out_valid=0
//   occupancy  out  2        number of held entries (0..2; max 1 when SKID=0)
// BEHAVIOUR
//   - Internal: main entry M (drives outputs) and, if SKID=1, skid entry S; each has valid bit.
//   - accept = in_valid & in_ready; fire = out_valid & out_ready; out_valid = M.valid.
//   - Reset (rst=1 at posedge): M.valid=S.valid=0, M/S data=0, M/S ctrl=BUBBLE_CTRL;
//     out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0; in_ready=1 from first cycle after.
//     Handshakes in a cycle with rst=1 are ignored; rst dominates flush.
//   - Latency: entry accepted at edge N is on outputs after edge N (1 cycle); throughput 1/cycle.
//   - SKID=1, in_ready is a flop = !S.valid (next-state value):
//       M empty, accept            -> M <= in
//       M full, fire, accept       -> M <= in (S stays empty)
//       M full, fire, no accept    -> M.valid <= 0
//       M full, !fire, accept      -> S <= in; in_ready drops next cycle
//       S full, fire               -> M <= S, S.valid <= 0, in_ready rises next cycle
//       S full, !fire              -> hold everything
//   - SKID=0: in_ready = !M.valid | out_ready (combinational);
//       accept -> M <= in; fire & !accept -> M.valid <= 0.
//   - Stability: while out_valid=1 & out_ready=0, out_ctrl/out_data must not change.
//   - flush=1 at posedge: M.valid=S.valid <= 0 next cycle, any same-cycle accept is dropped;
//     data regs may keep stale values but out_ctrl = BUBBLE_CTRL; in_ready=1 next cycle.
//   - No entry is ever duplicated or lost absent flush/rst; order is strictly FIFO.
//   - occupancy = M.valid + S.valid, registered, consistent with valids every cycle.
// TESTING
//   1. Reset: rst=1 two cycles with in_valid=1 -> out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1 after.
//   2. Streaming, out_ready=1, in 0x10,0x11,0x12 back-to-back -> same values out 1 cycle later, no gaps.
//   3. SKID=1 stall: send 0xA,0xB,0xC with out_ready=0 -> 0xA held, 0xB in skid, occupancy=2,
//      in_ready=0, 0xC waits; release -> 0xA,0xB,0xC emitted in order on consecutive cycles.
//   4. Flush with occupancy=2 and in_valid=1 same cycle -> next cycle out_valid=0,
//      out_ctrl=BUBBLE_CTRL, occupancy=0; flushed input never appears.
//   5. SKID=0, M full, out_ready=1, in_valid=1 -> in_ready=1 same cycle, replacement with no bubble.
//   6. Random valid/ready/flush, 10k cycles vs scoreboard -> no loss, dup, reorder or stability violation.

Source files
------------

// File: rtl/pipeline_stage_skid.sv
// Elastic valid/ready pipeline register with flush; optional skid entry keeps
// full throughput while in_ready comes straight from a flop.
module pipeline_stage_skid #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 4,
  parameter int                SKID        = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_vld, s_vld, rdy_q;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic [1:0]        occ_q;

  logic accept, fire;
  logic m_vld_n, s_vld_n, m_ld_in, m_ld_s, s_ld_in;

  assign in_ready = (SKID != 0) ? rdy_q : (!m_vld | out_ready);
  assign accept   = in_valid & in_ready;
  assign fire     = m_vld & out_ready;

  // S only ever holds the entry that arrived while M was stalled, so it is
  // always older than anything upstream: draining S into M keeps FIFO order.
  always_comb begin
    m_vld_n = m_vld;
    s_vld_n = s_vld;
    m_ld_in = 1'b0;
    m_ld_s  = 1'b0;
    s_ld_in = 1'b0;
    if (s_vld) begin
      if (fire) begin
        m_ld_s  = 1'b1;
        s_vld_n = 1'b0;
      end
    end else if (!m_vld || fire) begin
      m_ld_in = accept;
      m_vld_n = accept;
    end else if (accept && (SKID != 0)) begin
      s_ld_in = 1'b1;
      s_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      m_ctrl <= BUBBLE_CTRL;
      s_ctrl <= BUBBLE_CTRL;
      m_data <= '0;
      s_data <= '0;
      rdy_q  <= 1'b1;
      occ_q  <= 2'd0;
    end else if (flush) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      rdy_q  <= 1'b1;
      occ_q  <= 2'd0;
    end else begin
      m_vld <= m_vld_n;
      s_vld <= s_vld_n;
      if (m_ld_in) begin
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end else if (m_ld_s) begin
        m_ctrl <= s_ctrl;
        m_data <= s_data;
      end
      if (s_ld_in) begin
        s_ctrl <= in_ctrl;
        s_data <= in_data;
      end
      rdy_q <= !s_vld_n;
      occ_q <= {1'b0, m_vld_n} + {1'b0, s_vld_n};
    end
  end

  assign out_valid = m_vld;
  assign out_ctrl  = m_vld ? m_ctrl : BUBBLE_CTRL;
  assign out_data  = m_data;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Drives a SKID=1 and a SKID=0 stage with shared stimulus and checks both
// against a queue model of the stage contents.
module tb_pipeline_stage_skid;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] BUB = 4'hA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic [1:0]    rdy, ov;
  logic [CW-1:0] oc [2];
  logic [DW-1:0] od [2];
  logic [1:0]    occ [2];

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .BUBBLE_CTRL(BUB)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]));

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .BUBBLE_CTRL(BUB)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model: each stage is a FIFO of {ctrl,data}, capacity 2 (skid) or 1.
  logic [CW+DW-1:0] q [2][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int k);
    if (k == 1) return q[k].size() < 2;
    return (q[k].size() == 0) || out_ready;
  endfunction

  task automatic cyc(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input bit ordy, input bit fl, input bit r);
    @(negedge clk);
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      int sz;
      logic [CW+DW-1:0] head;
      bit er, acc, fir;
      sz   = q[k].size();
      head = (sz > 0) ? q[k][0] : '0;
      er   = exp_rdy(k);
      if (chk_en) begin
        chk($sformatf("s%0d.in_ready", k), 64'(rdy[k]), 64'(er));
        chk($sformatf("s%0d.out_valid", k), 64'(ov[k]), 64'(sz > 0));
        chk($sformatf("s%0d.occupancy", k), 64'(occ[k]), 64'(sz));
        chk($sformatf("s%0d.out_ctrl", k), 64'(oc[k]), 64'((sz > 0) ? head[CW+DW-1:DW] : BUB));
        if (sz > 0) chk($sformatf("s%0d.out_data", k), 64'(od[k]), 64'(head[DW-1:0]));
      end
      if (r || fl) q[k].delete();
      else begin
        fir = (sz > 0) && ordy;
        acc = iv && er;
        if (fir) void'(q[k].pop_front());
        if (acc) q[k].push_back({c, d});
      end
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0;

    // reset held two cycles with in_valid high
    cyc(1, 4'h3, 32'h99, 1, 0, 1);
    chk_en = 1;
    cyc(1, 4'h3, 32'h99, 1, 0, 1);
    after_edge();
    chk("rst.out_valid", 64'(ov[1]), 0);
    chk("rst.out_ctrl", 64'(oc[1]), 64'(BUB));
    chk("rst.occupancy", 64'(occ[1]), 0);
    chk("rst.in_ready", 64'(rdy[1]), 1);

    // streaming
    cyc(1, 4'h1, 32'h10, 1, 0, 0);
    after_edge();
    chk("stream.first", 64'(od[1]), 64'h10);
    cyc(1, 4'h2, 32'h11, 1, 0, 0);
    cyc(1, 4'h3, 32'h12, 1, 0, 0);
    after_edge();
    chk("stream.last", 64'(od[1]), 64'h12);
    chk("stream.last_v", 64'(ov[1]), 1);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);

    // stall fills the skid entry, then release in order
    cyc(1, 4'h4, 32'hA, 0, 0, 0);
    cyc(1, 4'h5, 32'hB, 0, 0, 0);
    cyc(1, 4'h6, 32'hC, 0, 0, 0);
    after_edge();
    chk("stall.occ", 64'(occ[1]), 2);
    chk("stall.in_ready", 64'(rdy[1]), 0);
    chk("stall.head", 64'(od[1]), 64'hA);
    cyc(1, 4'h6, 32'hC, 1, 0, 0);
    after_edge();
    chk("release.b", 64'(od[1]), 64'hB);
    cyc(1, 4'h6, 32'hC, 1, 0, 0);
    after_edge();
    chk("release.c", 64'(od[1]), 64'hC);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);

    // flush with both entries held and a same-cycle input
    cyc(1, 4'h7, 32'hD0, 0, 0, 0);
    cyc(1, 4'h8, 32'hD1, 0, 0, 0);
    cyc(1, 4'h9, 32'hEE, 0, 1, 0);
    after_edge();
    chk("flush.occ", 64'(occ[1]), 0);
    chk("flush.out_valid", 64'(ov[1]), 0);
    chk("flush.out_ctrl", 64'(oc[1]), 64'(BUB));
    chk("flush.in_ready", 64'(rdy[1]), 1);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);

    // single-entry stage replaces a full M with no bubble
    cyc(1, 4'h1, 32'h20, 1, 0, 0);
    cyc(1, 4'h2, 32'h21, 1, 0, 0);
    chk("s0.replace.rdy", 64'(rdy[0]), 1);
    after_edge();
    chk("s0.replace.data", 64'(od[0]), 64'h21);
    chk("s0.replace.v", 64'(ov[0]), 1);

    // random valid/ready/flush/reset
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 9) < 7, CW'($urandom), $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2,
          $urandom_range(0, 999) < 2);
    end
    cyc(0, 4'h0, 32'h0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
